relu_backward: RTL and testbench

- Backward-pass ReLU stage; downstream of the forward ReLU in backprop order.
- Reads the forward input tensor x (handle a) and the upstream gradient dy (handle b), element-wise.
- Writes dx to handle d: dx[i] = dy[i] when x[i][31]==0, else +0.0 (32'h0000_0000).
- Copies the tensor header from a to d. Started by the layer sequencer via go/done, like the other fpu ops.

---
 rtl/relu_backward_pkg.sv | 23 ++
 rtl/relu_backward_if.sv | 23 ++
 rtl/relu_bw_fetch2.sv | 51 +++++
 rtl/relu_backward.sv | 133 +++++++++++++
 tb/tb_relu_backward.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/relu_backward_pkg.sv
// Shared types and constants for the fpu element-wise op family.
package fpu_pkg;

  localparam int          HDR_NDIMS_IDX = 0;
  localparam logic [31:0] FP_ZERO       = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    RD_N,
    WR_H,
    RD_H,
    LOOP,
    LOAD,
    WRITE,
    DONE
  } relu_bw_state_t;

  // Sign bit only: -0.0 and negative NaNs count as negative.
  function automatic logic is_neg(input logic [31:0] word);
    return word[31];
  endfunction

endpackage

// File: rtl/relu_backward_if.sv
// Memory handle: one request/done channel into a tensor region.
interface mem_handle #(parameter int DATA_W = 32);
  logic              r_en;
  logic              w_en;
  logic              avail;
  logic              write_through;
  logic              done;
  logic [DATA_W-1:0] ptr;
  logic [DATA_W-1:0] data_store;
  logic [DATA_W-1:0] data_load;
  logic [DATA_W-1:0] region_begin;
  logic [DATA_W-1:0] region_end;

  modport master (
    output r_en, w_en, avail, ptr, data_store, write_through,
    input  done, data_load, region_begin, region_end
  );

  modport slave (
    input  r_en, w_en, avail, ptr, data_store, write_through,
    output done, data_load, region_begin, region_end
  );
endinterface

// File: rtl/relu_bw_fetch2.sv
// Dual-read capture unit: requests one word from each of two handles and
// holds each independently until both have arrived.
module relu_bw_fetch2
  import fpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              a_done,
  input  logic              b_done,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              a_req,
  output logic              b_req,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] dy,
  output logic              both_valid
);

  logic x_vld;
  logic dy_vld;

  assign a_req      = en && !x_vld;
  assign b_req      = en && !dy_vld;
  assign both_valid = x_vld && dy_vld;

  // Capture each operand on its own done; leaving en clears the capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_vld  <= 1'b0;
      dy_vld <= 1'b0;
      x      <= '0;
      dy     <= '0;
    end else if (!en) begin
      x_vld  <= 1'b0;
      dy_vld <= 1'b0;
    end else begin
      if (a_done && a_req) begin
        x     <= a_data;
        x_vld <= 1'b1;
      end
      if (b_done && b_req) begin
        dy     <= b_data;
        dy_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/relu_backward.sv
// Backward ReLU: dx = (x >= +0 by sign bit) ? dy : +0, header copied from a.
//
// state | meaning
// IDLE  | waiting for go
// RD_N  | reading ndims from a header word0
// WR_H  | writing captured header word to d
// RD_H  | reading next a header word
// LOOP  | end-of-region test on d.ptr
// LOAD  | fetching x and dy for one element
// WRITE | writing dx for one element
// DONE  | run finished, waiting for go to drop
module relu_backward
  import fpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_DIMS = 2
) (
  input  logic        clk,
  input  logic        rst,
  mem_handle.master   a,
  mem_handle.master   b,
  mem_handle.master   d,
  input  logic        go,
  output logic        done,
  output logic        err,
  output logic [31:0] elem_cnt
);

  localparam int HDR_W = $clog2(MAX_DIMS + 1);

  relu_bw_state_t    state, state_nxt;
  logic [HDR_W-1:0]  hdr_left;
  logic              fetch_en, a_req, b_req, both_valid;
  logic [DATA_W-1:0] x_q, dy_q;
  logic              a_rd, a_hs, b_hs, d_wr, d_hs;
  logic              ndims_ok;

  relu_bw_fetch2 #(.DATA_W(DATA_W)) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .en         (fetch_en),
    .a_done     (a.done),
    .b_done     (b.done),
    .a_data     (a.data_load),
    .b_data     (b.data_load),
    .a_req      (a_req),
    .b_req      (b_req),
    .x          (x_q),
    .dy         (dy_q),
    .both_valid (both_valid)
  );

  assign fetch_en = (state == LOAD);
  assign a_rd     = (state == RD_N) || (state == RD_H) || a_req;
  assign d_wr     = (state == WR_H) || (state == WRITE);
  assign a_hs     = a.done && a_rd;
  assign b_hs     = b.done && b_req;
  assign d_hs     = d.done && d_wr;
  assign ndims_ok = (a.data_load != '0) && (a.data_load <= DATA_W'(MAX_DIMS));

  assign a.r_en          = a_rd;
  assign a.avail         = a_rd;
  assign a.w_en          = 1'b0;
  assign a.data_store    = FP_ZERO;
  assign a.write_through = 1'b0;
  assign b.r_en          = b_req;
  assign b.avail         = b_req;
  assign b.w_en          = 1'b0;
  assign b.data_store    = FP_ZERO;
  assign b.write_through = 1'b0;
  assign d.r_en          = 1'b0;
  assign d.w_en          = d_wr;
  assign d.avail         = d_wr;
  assign d.write_through = (state == WRITE) && (d.ptr == d.region_end - DATA_W'(1));
  assign done            = (state == DONE);

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = RD_N;
      RD_N:    if (a_hs) state_nxt = ndims_ok ? WR_H : DONE;
      WR_H:    if (d_hs) state_nxt = (hdr_left == '0) ? LOOP : RD_H;
      RD_H:    if (a_hs) state_nxt = WR_H;
      LOOP:    state_nxt = (d.ptr == d.region_end) ? DONE : LOAD;
      LOAD:    if (both_valid) state_nxt = WRITE;
      WRITE:   if (d_hs) state_nxt = LOOP;
      DONE:    if (!go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointers, header countdown, write data and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      err          <= 1'b0;
      elem_cnt     <= '0;
      hdr_left     <= '0;
      a.ptr        <= '0;
      b.ptr        <= '0;
      d.ptr        <= '0;
      d.data_store <= '0;
    end else begin
      state <= state_nxt;
      if (a_hs) a.ptr <= a.ptr + DATA_W'(1);
      if (b_hs) b.ptr <= b.ptr + DATA_W'(1);
      if (d_hs) d.ptr <= d.ptr + DATA_W'(1);
      if (state == IDLE && go) begin
        a.ptr    <= a.region_begin + DATA_W'(HDR_NDIMS_IDX);
        b.ptr    <= b.region_begin;
        d.ptr    <= d.region_begin;
        err      <= 1'b0;
        elem_cnt <= '0;
      end
      if (state == RD_N && a_hs) begin
        if (ndims_ok) begin
          // b carries its own header copy; skip straight past it.
          b.ptr        <= b.region_begin + a.data_load + DATA_W'(1);
          hdr_left     <= a.data_load[HDR_W-1:0];
          d.data_store <= a.data_load;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == RD_H && a_hs) d.data_store <= a.data_load;
      if (state == WR_H && d_hs && hdr_left != '0) hdr_left <= hdr_left - 1'b1;
      if (state == LOAD && both_valid) d.data_store <= is_neg(x_q) ? FP_ZERO : dy_q;
      if (state == WRITE && d_hs) elem_cnt <= elem_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Bench for relu_backward: three memory-handle responders with random
// latency, expected d writes queued at setup and popped on each write.
module tb_relu_backward;

  localparam int A_BASE = 0;
  localparam int B_BASE = 256;
  localparam int D_BASE = 512;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wt;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic        done, err;
  logic [31:0] elem_cnt;

  mem_handle #(.DATA_W(32)) a_if ();
  mem_handle #(.DATA_W(32)) b_if ();
  mem_handle #(.DATA_W(32)) d_if ();

  relu_backward #(.DATA_W(32), .MAX_DIMS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a_if),
    .b        (b_if),
    .d        (d_if),
    .go       (go),
    .done     (done),
    .err      (err),
    .elem_cnt (elem_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [31:0] tx  [0:63];
  logic [31:0] tdy [0:63];
  wr_t         sb [$];
  int n_cmp = 0, n_mis = 0;
  int cyc = 0, a_first_cyc = 0;
  int a_reads = 0, b_reads = 0, d_writes = 0;
  int lat_max = 2;

  task automatic chk_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever @(negedge clk) cyc++;

  // a responder (read only)
  initial begin
    int cnt = 0, lat = 0;
    a_if.done = 1'b0;
    a_if.data_load = '0;
    forever @(negedge clk) begin
      if (rst) begin
        a_if.done = 1'b0;
        cnt = 0;
      end else if (a_if.done) begin
        a_if.done = 1'b0;
      end else if (a_if.r_en && a_if.avail) begin
        if (cnt >= lat) begin
          a_if.done = 1'b1;
          a_if.data_load = mem[a_if.ptr[9:0]];
          if (a_reads == 0) a_first_cyc = cyc;
          a_reads++;
          cnt = 0;
          lat = $urandom_range(0, lat_max);
        end else cnt++;
      end
    end
  end

  // b responder (read only)
  initial begin
    int cnt = 0, lat = 0;
    b_if.done = 1'b0;
    b_if.data_load = '0;
    forever @(negedge clk) begin
      if (rst) begin
        b_if.done = 1'b0;
        cnt = 0;
      end else if (b_if.done) begin
        b_if.done = 1'b0;
      end else if (b_if.r_en && b_if.avail) begin
        if (cnt >= lat) begin
          b_if.done = 1'b1;
          b_if.data_load = mem[b_if.ptr[9:0]];
          b_reads++;
          cnt = 0;
          lat = $urandom_range(0, lat_max);
        end else cnt++;
      end
    end
  end

  // d responder (write only), checks each write against the scoreboard
  initial begin
    int cnt = 0, lat = 0;
    wr_t e;
    d_if.done = 1'b0;
    d_if.data_load = '0;
    forever @(negedge clk) begin
      if (rst) begin
        d_if.done = 1'b0;
        cnt = 0;
      end else if (d_if.done) begin
        d_if.done = 1'b0;
      end else if (d_if.w_en && d_if.avail) begin
        if (cnt >= lat) begin
          d_if.done = 1'b1;
          d_writes++;
          if (sb.size() == 0) chk_eq("sb_extra_write", 96'd1, 96'd0);
          else begin
            e = sb.pop_front();
            chk_eq("d_write", {d_if.ptr, d_if.data_store, 31'd0, d_if.write_through},
                   {e.addr, e.data, 31'd0, e.wt});
          end
          cnt = 0;
          lat = $urandom_range(0, lat_max);
        end else cnt++;
      end
    end
  end

  task automatic setup(input int nd, input int d0, input int d1, input int n);
    int h;
    wr_t e;
    h = nd + 1;
    sb.delete();
    a_reads = 0; b_reads = 0; d_writes = 0;
    mem[A_BASE] = nd;
    mem[B_BASE] = 32'hBAD0_0000;
    for (int k = 1; k < h; k++) begin
      mem[A_BASE + k] = (k == 1) ? d0 : (k == 2) ? d1 : 32'd9;
      mem[B_BASE + k] = 32'hBAD0_0000 + k;
    end
    for (int i = 0; i < n; i++) begin
      mem[A_BASE + h + i] = tx[i];
      mem[B_BASE + h + i] = tdy[i];
    end
    a_if.region_begin = A_BASE; a_if.region_end = A_BASE + h + n;
    b_if.region_begin = B_BASE; b_if.region_end = B_BASE + h + n;
    d_if.region_begin = D_BASE; d_if.region_end = D_BASE + h + n;
    if (nd >= 1 && nd <= 2) begin
      for (int k = 0; k < h; k++) begin
        e.addr = D_BASE + k; e.data = mem[A_BASE + k]; e.wt = 1'b0;
        sb.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
        e.addr = D_BASE + h + i;
        e.data = tx[i][31] ? 32'h0 : tdy[i];
        e.wt   = (i == n - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 4000 && !done; k++) @(negedge clk);
    chk_eq({tag, "_done_seen"}, {95'd0, done}, 96'd1);
  endtask

  task automatic run(input string tag, input int nd, input int d0, input int d1,
                     input int n, input int hold);
    logic bad;
    int h;
    bad = (nd == 0 || nd > 2);
    h = nd + 1;
    setup(nd, d0, d1, n);
    @(negedge clk);
    go = 1'b1;
    wait_done(tag);
    chk_eq({tag, "_err"}, {95'd0, err}, {95'd0, bad});
    chk_eq({tag, "_elem_cnt"}, {64'd0, elem_cnt}, bad ? 96'd0 : 96'(n));
    chk_eq({tag, "_sb_left"}, 96'(sb.size()), 96'd0);
    chk_eq({tag, "_a_reads"}, 96'(a_reads), bad ? 96'd1 : 96'(h + n));
    chk_eq({tag, "_b_reads"}, 96'(b_reads), bad ? 96'd0 : 96'(n));
    chk_eq({tag, "_d_writes"}, 96'(d_writes), bad ? 96'd0 : 96'(h + n));
    if (bad) chk_eq({tag, "_err_latency"}, {95'd0, (cyc - a_first_cyc) <= 5}, 96'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk_eq({tag, "_hold_done"}, {95'd0, done}, 96'd1);
      chk_eq({tag, "_hold_writes"}, 96'(d_writes), 96'(h + n));
    end
    go = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq({tag, "_idle"}, {95'd0, done}, 96'd0);
  endtask

  task automatic load_t1();
    tx[0] = 32'h4040_0000; tx[1] = 32'hBF80_0000; tx[2] = 32'h0000_0000; tx[3] = 32'h8000_0000;
    tdy[0] = 32'h3F00_0000; tdy[1] = 32'h3E80_0000; tdy[2] = 32'h4000_0000; tdy[3] = 32'h40E0_0000;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    a_if.region_begin = '0; a_if.region_end = '0;
    b_if.region_begin = '0; b_if.region_end = '0;
    d_if.region_begin = '0; d_if.region_end = '0;
    repeat (3) @(negedge clk);
    chk_eq("reset_status", {64'd0, done, err, elem_cnt[29:0]}, 96'd0);
    chk_eq("reset_enables", {90'd0, a_if.r_en, a_if.avail, b_if.r_en, b_if.avail,
                             d_if.w_en, d_if.write_through}, 96'd0);
    chk_eq("reset_ptrs", {a_if.ptr, b_if.ptr, d_if.ptr}, 96'd0);
    chk_eq("reset_store", {64'd0, d_if.data_store}, 96'd0);
    rst = 1'b0;
    @(negedge clk);

    load_t1();
    run("t1", 1, 4, 0, 4, 0);

    tx[0] = 32'h3F80_0000; tx[1] = 32'h3F80_0000; tx[2] = 32'hC000_0000; tx[3] = 32'hC000_0000;
    tdy[0] = 32'h3F80_0000; tdy[1] = 32'h4000_0000; tdy[2] = 32'h4040_0000; tdy[3] = 32'h4080_0000;
    run("t2", 2, 2, 2, 4, 0);

    run("t_err", 3, 1, 1, 0, 0);

    lat_max = 7;
    for (int i = 0; i < 64; i++) begin
      tx[i]  = $urandom;
      tdy[i] = $urandom;
      if (i % 8 == 5) tx[i] = 32'hFFC0_0001;
      if (i % 8 == 6) tx[i] = 32'h7FC0_0000;
      if (i % 8 == 7) tx[i] = 32'h8000_0000;
      if (i % 8 == 4) tx[i] = 32'h0000_0000;
    end
    run("t_rand", 2, 8, 8, 64, 0);
    lat_max = 0;
    run("t_rand0", 2, 8, 8, 64, 0);
    lat_max = 2;

    // reset while element 2 is being written
    load_t1();
    setup(1, 4, 0, 4);
    @(negedge clk);
    go = 1'b1;
    begin
      int k;
      for (k = 0; k < 2000 && !(d_if.w_en && d_if.ptr == D_BASE + 4); k++) @(negedge clk);
      chk_eq("rst_reach_write2", {95'd0, d_if.w_en}, 96'd1);
    end
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    chk_eq("rst_mid_enables", {89'd0, a_if.r_en, a_if.avail, b_if.r_en, b_if.avail,
                               d_if.w_en, d_if.avail, done}, 96'd0);
    chk_eq("rst_mid_status", {64'd0, err, elem_cnt[30:0]}, 96'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    load_t1();
    run("t_after_rst", 1, 4, 0, 4, 0);

    run("t_empty", 1, 0, 0, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
